xc_sha3_idx_decode: RTL and testbench

//  Inverse of the xc.sha3 lane-index functions. Takes a shifted lane offset
//  (lane << shamt) and recovers Keccak coordinates x = lane%5, y = lane/5.

---
 rtl/xc_sha3_idx_decode.sv | 128 ++++++++++++
 tb/tb_xc_sha3_idx_decode.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xc_sha3_idx_decode.sv
// xc.sha3 lane-index decoder: shifted lane offset back to Keccak (x,y),
// with optional inverse-pi. Multi-cycle, valid/ready on both sides.
module xc_sha3_idx_decode #(
    parameter int IDXW   = 32,
    parameter bit INV_EN = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [IDXW-1:0] req_idx,
    input  logic [1:0]      req_shamt,
    input  logic            req_inv,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [2:0]      rsp_x,
    output logic [2:0]      rsp_y,
    output logic            rsp_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_PI   = 2'd2;
    localparam logic [1:0] S_RSP  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [4:0]      rem_q, rem_d;
    logic [2:0]      q_q, q_d;
    logic            inv_q, inv_d;
    logic [2:0]      x_q, x_d;
    logic [2:0]      y_q, y_d;
    logic            err_q, err_d;

    logic [IDXW-1:0] lane;
    logic [IDXW-1:0] mask;
    logic            bad;
    logic [4:0]      pi_sum;

    function automatic logic [2:0] mod5(input logic [4:0] s);
        logic [4:0] r;
        r = s;
        if (r >= 5'd10) r = r - 5'd10;
        if (r >= 5'd5)  r = r - 5'd5;
        return 3'(r);
    endfunction

    // Range check runs on the full-width lane so high bits cannot alias.
    assign lane   = req_idx >> req_shamt;
    assign mask   = (IDXW'(1) << req_shamt) - IDXW'(1);
    assign bad    = (|(req_idx & mask)) || (lane > IDXW'(24));
    assign pi_sum = {2'b00, rem_q[2:0]} + {1'b0, q_q, 1'b0} + {2'b00, q_q};

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RSP);
    assign rsp_x     = x_q;
    assign rsp_y     = y_q;
    assign rsp_err   = err_q;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        q_d     = q_q;
        inv_d   = inv_q;
        x_d     = x_q;
        y_d     = y_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    inv_d = req_inv & INV_EN;
                    if (bad) begin
                        x_d     = 3'd0;
                        y_d     = 3'd0;
                        err_d   = 1'b1;
                        state_d = S_RSP;
                    end else begin
                        rem_d   = lane[4:0];
                        q_d     = 3'd0;
                        state_d = S_DIV;
                    end
                end
            end
            S_DIV: begin
                if (rem_q >= 5'd5) begin
                    rem_d = rem_q - 5'd5;
                    q_d   = q_q + 3'd1;
                end else if (inv_q) begin
                    state_d = S_PI;
                end else begin
                    x_d     = rem_q[2:0];
                    y_d     = q_q;
                    err_d   = 1'b0;
                    state_d = S_RSP;
                end
            end
            S_PI: begin
                x_d     = mod5(pi_sum);
                y_d     = rem_q[2:0];
                err_d   = 1'b0;
                state_d = S_RSP;
            end
            default: begin
                if (rsp_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            rem_q   <= 5'd0;
            q_q     <= 3'd0;
            inv_q   <= 1'b0;
            x_q     <= 3'd0;
            y_q     <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            inv_q   <= inv_d;
            x_q     <= x_d;
            y_q     <= y_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_xc_sha3_idx_decode.sv
// Self-checking bench for xc_sha3_idx_decode against a lane/Keccak model.
// Directed cases, backpressure, mid-op reset, sweep and random stimulus.
module tb_xc_sha3_idx_decode;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_idx = '0;
    logic [1:0]  req_shamt = '0;
    logic        req_inv = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [2:0]  rsp_x;
    logic [2:0]  rsp_y;
    logic        rsp_err;

    int vectors = 0;
    int miscompares = 0;

    xc_sha3_idx_decode #(.IDXW(32), .INV_EN(1'b1)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_idx   (req_idx),
        .req_shamt (req_shamt),
        .req_inv   (req_inv),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_x     (rsp_x),
        .rsp_y     (rsp_y),
        .rsp_err   (rsp_err)
    );

    always #5 clock = ~clock;

    // Reference: plain lane arithmetic, inverse-pi by searching the forward map.
    function automatic void model(input logic [31:0] idx, input logic [1:0] sh,
                                  input bit inv, output logic [2:0] ex,
                                  output logic [2:0] ey, output logic ee,
                                  output int el);
        longint unsigned p, lane;
        int ix, iy;
        p    = longint'(1) << sh;
        lane = longint'(idx) / p;
        ee   = ((longint'(idx) % p) != 0) || (lane > 24);
        ex   = 3'd0;
        ey   = 3'd0;
        el   = 1;
        if (!ee) begin
            ix = int'(lane % 5);
            iy = int'(lane / 5);
            el = iy + 2 + (inv ? 1 : 0);
            ex = 3'(ix);
            ey = 3'(iy);
            if (inv) begin
                for (int a = 0; a < 5; a++)
                    for (int b = 0; b < 5; b++)
                        if (b == ix && ((2 * a + 3 * b) % 5) == iy) begin
                            ex = 3'(a);
                            ey = 3'(b);
                        end
            end
        end
    endfunction

    task automatic run_req(input logic [31:0] idx, input logic [1:0] sh,
                           input logic inv, output logic [2:0] ox,
                           output logic [2:0] oy, output logic oe,
                           output int lat);
        @(negedge clock);
        req_valid = 1'b1;
        req_idx   = idx;
        req_shamt = sh;
        req_inv   = inv;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_idx   = $urandom;
        req_shamt = 2'($urandom);
        req_inv   = 1'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
        end
        ox = rsp_x;
        oy = rsp_y;
        oe = rsp_err;
    endtask

    task automatic finish_rsp();
        @(negedge clock);
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_x !== 3'd0 ||
            rsp_y !== 3'd0 || rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: rdy=%b vld=%b x=%0d y=%0d err=%b want 1 0 0 0 0",
                     req_ready, rsp_valid, rsp_x, rsp_y, rsp_err);
        end
    endtask

    task automatic test_directed();
        logic [31:0] idx [5] = '{32'h2C, 32'd24, 32'd0, 32'd2, 32'h8000_0008};
        logic [1:0]  sh  [5] = '{2'd2, 2'd0, 2'd3, 2'd0, 2'd0};
        logic        inv [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0]  wx  [5] = '{3'd1, 3'd4, 3'd0, 3'd2, 3'd0};
        logic [2:0]  wy  [5] = '{3'd2, 3'd4, 3'd0, 3'd2, 3'd0};
        logic        we  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int          wl  [5] = '{4, 6, 2, 3, 1};
        logic [2:0] ox, oy;
        logic oe;
        int ol;
        for (int i = 0; i < 5; i++) begin
            run_req(idx[i], sh[i], inv[i], ox, oy, oe, ol);
            vectors++;
            if (ox !== wx[i] || oy !== wy[i] || oe !== we[i] || ol != wl[i]) begin
                miscompares++;
                $display("FAIL directed[%0d]: got x=%0d y=%0d err=%b lat=%0d want x=%0d y=%0d err=%b lat=%0d",
                         i, ox, oy, oe, ol, wx[i], wy[i], we[i], wl[i]);
            end
            finish_rsp();
        end
    endtask

    task automatic test_errors();
        logic [31:0] idx [3] = '{32'd25, 32'h05, 32'hFFFF_FFF0};
        logic [1:0]  sh  [3] = '{2'd0, 2'd2, 2'd3};
        logic [2:0] ox, oy;
        logic oe;
        int ol;
        for (int i = 0; i < 3; i++) begin
            run_req(idx[i], sh[i], 1'b1, ox, oy, oe, ol);
            vectors++;
            if (ox !== 3'd0 || oy !== 3'd0 || oe !== 1'b1 || ol != 1) begin
                miscompares++;
                $display("FAIL error[%0d]: got x=%0d y=%0d err=%b lat=%0d want 0 0 1 1",
                         i, ox, oy, oe, ol);
            end
            finish_rsp();
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] ox, oy;
        logic oe;
        int ol;
        int bad;
        run_req(32'd34, 2'd1, 1'b0, ox, oy, oe, ol);
        vectors++;
        if (ox !== 3'd2 || oy !== 3'd3 || oe !== 1'b0 || ol != 5) begin
            miscompares++;
            $display("FAIL bp_first: got x=%0d y=%0d err=%b lat=%0d want 2 3 0 5",
                     ox, oy, oe, ol);
        end
        @(negedge clock);
        req_valid = 1'b1;
        req_idx   = 32'd3;
        req_shamt = 2'd0;
        req_inv   = 1'b0;
        bad = 0;
        repeat (5) begin
            @(posedge clock);
            #1;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_x !== 3'd2 ||
                rsp_y !== 3'd3 || rsp_err !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL bp_hold: %0d unstable cycles, want 0", bad);
        end
        finish_rsp();
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release: vld=%b rdy=%b want 0 1", rsp_valid, req_ready);
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        vectors++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_accept: rdy=%b vld=%b want 0 0", req_ready, rsp_valid);
        end
        @(posedge clock);
        #1;
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_x !== 3'd3 || rsp_y !== 3'd0 || rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_next: vld=%b x=%0d y=%0d err=%b want 1 3 0 0",
                     rsp_valid, rsp_x, rsp_y, rsp_err);
        end
        finish_rsp();
    endtask

    task automatic test_reset_mid();
        int bad;
        @(negedge clock);
        req_valid = 1'b1;
        req_idx   = 32'd24;
        req_shamt = 2'd0;
        req_inv   = 1'b1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_x !== 3'd0 ||
            rsp_y !== 3'd0 || rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: vld=%b rdy=%b x=%0d y=%0d err=%b want 0 1 0 0 0",
                     rsp_valid, req_ready, rsp_x, rsp_y, rsp_err);
        end
        bad = 0;
        repeat (10) begin
            @(posedge clock);
            #1;
            if (rsp_valid !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL reset_stale: %0d cycles with rsp_valid, want 0", bad);
        end
    endtask

    task automatic test_sweep();
        logic [2:0] ox, oy, ex, ey;
        logic oe, ee;
        int ol, el;
        for (int lane = 0; lane < 25; lane++)
            for (int s = 0; s < 4; s++)
                for (int v = 0; v < 2; v++) begin
                    model(32'(lane) << s, 2'(s), v[0], ex, ey, ee, el);
                    run_req(32'(lane) << s, 2'(s), v[0], ox, oy, oe, ol);
                    vectors++;
                    if (ox !== ex || oy !== ey || oe !== ee || ol != el) begin
                        miscompares++;
                        $display("FAIL sweep l=%0d s=%0d inv=%0d: got x=%0d y=%0d err=%b lat=%0d want x=%0d y=%0d err=%b lat=%0d",
                                 lane, s, v, ox, oy, oe, ol, ex, ey, ee, el);
                    end
                    finish_rsp();
                end
    endtask

    task automatic test_random();
        logic [31:0] idx;
        logic [1:0] s;
        logic inv;
        logic [2:0] ox, oy, ex, ey;
        logic oe, ee;
        int ol, el;
        for (int i = 0; i < 200; i++) begin
            s   = 2'($urandom);
            inv = 1'($urandom);
            case ($urandom_range(0, 3))
                0: idx = $urandom;
                1: idx = 32'($urandom_range(0, 31)) << s;
                2: idx = (32'($urandom_range(0, 24)) << s) | 32'($urandom_range(0, 3));
                default: idx = (32'($urandom_range(0, 24)) << s) | (32'd1 << $urandom_range(5, 31));
            endcase
            model(idx, s, inv, ex, ey, ee, el);
            run_req(idx, s, inv, ox, oy, oe, ol);
            vectors++;
            if (ox !== ex || oy !== ey || oe !== ee || ol != el) begin
                miscompares++;
                $display("FAIL random idx=%h s=%0d inv=%b: got x=%0d y=%0d err=%b lat=%0d want x=%0d y=%0d err=%b lat=%0d",
                         idx, s, inv, ox, oy, oe, ol, ex, ey, ee, el);
            end
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clock);
            finish_rsp();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
